ctrl_sequencer: RTL
===================

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 10, program-counter width.
REQ-002 SHALL have parameter INSTR_W, default 9, instruction width.
REQ-003 SHALL have parameter OP_W, default 5, opcode field width (Instr[INSTR_W-1 -: OP_W]); IMM_W = INSTR_W-OP_W.
REQ-004 SHALL have parameter MEM_TO, default 15, max MEM_WAIT cycles before timeout.
REQ-005 SHALL have ports:
 Clk  in  1  clock, rising edge;
 Reset_n  in  1  asynchronous active-low reset;
 Start  in  1  leave HALT, restart at PC 0;
 Instr_i  in  INSTR_W  fetched instruction;
 Instr_valid_i  in  1  Instr_i valid;
 Instr_ready_o  out  1  sequencer accepts instruction;
 Zero_i  in  1  compare flag from datapath;
 Br_target_i  in  PC_W  branch/jump target from LUT;
 Mem_ack_i  in  1  data memory completion;
 Mem_req_o  out  1  data memory request;
 Mem_we_o  out  1  data memory write enable;
 Reg_we_o  out  1  register-file write strobe;
 Alu_op_o  out  OP_W  latched opcode;
 Imm_o  out  IMM_W  latched immediate field;
 Pc_o  out  PC_W  program counter;
 Done_o  out  1  HLT executed;
 Err_o  out  1  sticky: illegal opcode or memory timeout.

Function
REQ-006 SHALL implement states HALT, FETCH, EXEC, MEM_WAIT; opcode encoding: ORR 0, XOR_B 1, XOR_G 2, AND 3, STR 4, LDR 5, STA 6, LDA 7, LD_LUT_L 8, LD_LUT_H 9, SET_L 10, SET_H 11, CMP 12, CMP_LS 13, LSL 14, LSR 15, ADD 16, BEQ 17, JMP 18, HLT 19.
REQ-007 SHALL, in HALT with Start=1, set Pc_o=0, clear Done_o and Err_o, go to FETCH; Start outside HALT ignored.
REQ-008 SHALL drive Instr_ready_o=1 only in FETCH; Instr_valid_i&Instr_ready_o latches opcode/immediate into Alu_op_o/Imm_o and enters EXEC next cycle; no valid -> stay FETCH.
REQ-009 SHALL, in EXEC, for opcodes 0-3, 8-11, 14-16: Reg_we_o=1 for that one cycle, Pc_o+1, go FETCH.
REQ-010 SHALL, in EXEC, for CMP/CMP_LS: Reg_we_o=0, Pc_o+1, go FETCH.
REQ-011 SHALL, in EXEC, for opcodes 4-7: go MEM_WAIT, clear timeout counter, PC unchanged.
REQ-012 SHALL, in MEM_WAIT: Mem_req_o=1; Mem_we_o=1 for STR/STA, 0 for LDR/LDA; held stable until Mem_ack_i.
REQ-013 SHALL, on Mem_ack_i=1 in MEM_WAIT: Reg_we_o=1 same cycle for LDR/LDA only, Pc_o+1, go FETCH.
REQ-014 SHALL count MEM_WAIT cycles without ack; at MEM_TO such cycles: set Err_o, go HALT, Pc_o held, Done_o=0.
REQ-015 SHALL, in EXEC: BEQ -> Pc_o=Br_target_i if Zero_i=1 else Pc_o+1; JMP -> Pc_o=Br_target_i; both go FETCH, Reg_we_o=0.
REQ-016 SHALL, in EXEC for HLT: Done_o=1 (held until Start), Pc_o held, go HALT.
REQ-017 SHALL treat opcodes 20..2^OP_W-1 as NOP: set Err_o, Pc_o+1, go FETCH.
REQ-018 SHALL increment Pc_o modulo 2^PC_W (2^PC_W-1 wraps to 0).
REQ-019 SHALL drive Mem_req_o, Mem_we_o, Reg_we_o to 0 in HALT and FETCH.
REQ-020 SHALL give latency: non-memory instruction 2 cycles (FETCH accepted + EXEC); memory instruction 2 + wait cycles, minimum 3.

Reset
REQ-021 SHALL, on Reset_n=0 at any time incl. mid-MEM_WAIT, asynchronously enter HALT: Pc_o=0, Alu_op_o=0, Imm_o=0, Done_o=0, Err_o=0, all strobes 0.
REQ-022 SHALL leave reset synchronously on first rising Clk with Reset_n=1; remain HALT until Start.

Verification
REQ-023 Start; feed ADD(16) imm 3, valid always -> Reg_we_o pulses 1 cycle in EXEC, Alu_op_o=16, Imm_o=3, Pc_o 0->1 after 2 cycles.
REQ-024 LDR, Mem_ack_i after 4 wait cycles -> Mem_req_o high 4 cycles, Mem_we_o=0, Reg_we_o on ack cycle, Pc_o+1; STR same -> Mem_we_o=1, no Reg_we_o.
REQ-025 BEQ, Br_target_i=0x155, Zero_i=1 -> Pc_o=0x155; Zero_i=0 -> Pc_o+1; JMP -> 0x155 regardless.
REQ-026 Pc_o=0x3FF, execute AND -> Pc_o=0x000; opcode 25 -> Err_o=1, Pc_o+1, execution continues.
REQ-027 LDA with no ack for 15 cycles -> Err_o=1, HALT, Mem_req_o=0; HLT opcode -> Done_o=1, Instr_ready_o=0 until Start.
REQ-028 Reset_n low mid-MEM_WAIT -> immediate HALT, Pc_o=0, Mem_req_o=0; Start ignored while in FETCH.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: four-state instruction sequencer (HALT, FETCH, EXEC, MEM_WAIT).
// It fetches one instruction per handshake and latches the opcode and immediate.
// It then issues register-write or data-memory strobes and advances the program
// counter, which wraps modulo 2^PC_W.
//
// Ports:
//   Clk, Reset_n         clock (rising edge), async active-low reset
//   Start                leave HALT and restart at PC 0
//   Instr_i/_valid_i     fetched instruction and its valid flag
//   Instr_ready_o        high only in FETCH
//   Zero_i, Br_target_i  branch condition and branch/jump target
//   Mem_ack_i            data memory completion
//   Mem_req_o, Mem_we_o  data memory request / write enable
//   Reg_we_o             register-file write strobe
//   Alu_op_o, Imm_o      latched opcode / immediate
//   Pc_o                 program counter
//   Done_o               HLT executed; held until Start
//   Err_o                sticky illegal-opcode / memory-timeout flag
//
// state    | meaning
// ---------+-------------------------------------------------
// HALT     | idle after reset, HLT or timeout; waits for Start
// FETCH    | Instr_ready_o high, latch instruction on valid
// EXEC     | decode latched opcode, update PC / strobes
// MEM_WAIT | Mem_req_o held until Mem_ack_i or timeout
module ctrl_sequencer #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int OP_W    = 5,
  parameter int MEM_TO  = 15
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    Start,
  input  logic [INSTR_W-1:0]      Instr_i,
  input  logic                    Instr_valid_i,
  output logic                    Instr_ready_o,
  input  logic                    Zero_i,
  input  logic [PC_W-1:0]         Br_target_i,
  input  logic                    Mem_ack_i,
  output logic                    Mem_req_o,
  output logic                    Mem_we_o,
  output logic                    Reg_we_o,
  output logic [OP_W-1:0]         Alu_op_o,
  output logic [INSTR_W-OP_W-1:0] Imm_o,
  output logic [PC_W-1:0]         Pc_o,
  output logic                    Done_o,
  output logic                    Err_o
);

  localparam int IMM_W = INSTR_W - OP_W;
  localparam int CNT_W = $clog2(MEM_TO + 1);

  localparam logic [OP_W-1:0] OP_STR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LDR = OP_W'(5);
  localparam logic [OP_W-1:0] OP_STA = OP_W'(6);
  localparam logic [OP_W-1:0] OP_LDA = OP_W'(7);

  typedef enum logic [1:0] {
    HALT     = 2'd0,
    FETCH    = 2'd1,
    EXEC     = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
  logic              reg_we;
  logic              is_store;
  logic              is_load;

  assign is_store = (op_q == OP_STR) || (op_q == OP_STA);
  assign is_load  = (op_q == OP_LDR) || (op_q == OP_LDA);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= HALT;
      pc_q     <= '0;
      op_q     <= '0;
      imm_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      op_q     <= op_d;
      imm_q    <= imm_d;
      done_q   <= done_d;
      err_q    <= err_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    op_d     = op_q;
    imm_d    = imm_q;
    done_d   = done_q;
    err_d    = err_q;
    to_cnt_d = to_cnt_q;
    reg_we   = 1'b0;

    case (state_q)
      HALT: begin
        if (Start) begin
          pc_d    = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (Instr_valid_i) begin
          op_d    = Instr_i[INSTR_W-1 -: OP_W];
          imm_d   = Instr_i[IMM_W-1:0];
          state_d = EXEC;
        end
      end

      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_q + PC_W'(1);
        case (op_q)
          OP_W'(0), OP_W'(1), OP_W'(2), OP_W'(3),
          OP_W'(8), OP_W'(9), OP_W'(10), OP_W'(11),
          OP_W'(14), OP_W'(15), OP_W'(16): reg_we = 1'b1;
          OP_W'(12), OP_W'(13): ;
          OP_STR, OP_LDR, OP_STA, OP_LDA: begin
            pc_d     = pc_q;
            to_cnt_d = CNT_W'(MEM_TO - 1);
            state_d  = MEM_WAIT;
          end
          OP_W'(17): if (Zero_i) pc_d = Br_target_i;
          OP_W'(18): pc_d = Br_target_i;
          OP_W'(19): begin
            pc_d    = pc_q;
            done_d  = 1'b1;
            state_d = HALT;
          end
          // Unassigned opcodes execute as NOP but leave a sticky error.
          default: err_d = 1'b1;
        endcase
      end

      MEM_WAIT: begin
        if (Mem_ack_i) begin
          reg_we  = is_load;
          pc_d    = pc_q + PC_W'(1);
          state_d = FETCH;
        end else if (to_cnt_q == '0) begin
          // MEM_TO-th unacknowledged cycle: abandon the access.
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          to_cnt_d = to_cnt_q - CNT_W'(1);
        end
      end

      default: state_d = HALT;
    endcase
  end

  assign Instr_ready_o = (state_q == FETCH);
  assign Mem_req_o     = (state_q == MEM_WAIT);
  assign Mem_we_o      = (state_q == MEM_WAIT) && is_store;
  assign Reg_we_o      = reg_we;
  assign Alu_op_o      = op_q;
  assign Imm_o         = imm_q;
  assign Pc_o          = pc_q;
  assign Done_o        = done_q;
  assign Err_o         = err_q;

endmodule
